// File: rtl/xaui_link_ctrl_pkg.sv
// rtl/xaui_link_ctrl_pkg.sv - shared types and constants for the XAUI link bring-up sequencer
package xaui_link_ctrl_pkg;

  localparam int LANES   = 4;
  localparam int STATE_W = 3;
  localparam int RETRY_W = 4;
  localparam int STAT_W  = 16;

  typedef enum logic [STATE_W-1:0] {
    ST_PWRDN      = 3'd0,
    ST_TXRST      = 3'd1,
    ST_RXRST      = 3'd2,
    ST_WAIT_LOCK  = 3'd3,
    ST_WAIT_ALIGN = 3'd4,
    ST_STABLE     = 3'd5,
    ST_UP         = 3'd6,
    ST_FAIL       = 3'd7
  } state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/xaui_link_ctrl_timer.sv
// rtl/xaui_link_ctrl_timer.sv - loadable down-counter shared by every hold and timeout phase
module xaui_link_ctrl_timer #(
  parameter int           W       = 24,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         i_clk,
  input  logic         i_reset_n,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  output logic         o_done
);

  logic [W-1:0] r_count;

  // Parks at zero so a late exit condition still sees done.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_count <= RST_VAL;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (r_count != '0) begin
      r_count <= r_count - W'(1);
    end
  end

  assign o_done = (r_count == '0);

endmodule

// File: rtl/xaui_link_ctrl.sv
// rtl/xaui_link_ctrl.sv - XAUI PHY power-up/reset/retry sequencer
// XAUI_LINK_CTRL_STATS_EN enables the flap and timeout statistics counters.
module xaui_link_ctrl
  import xaui_link_ctrl_pkg::*;
#(
  parameter int PWRDN_CYCLES       = 64,
  parameter int TX_RESET_CYCLES    = 16,
  parameter int RX_RESET_CYCLES    = 16,
  parameter int LOCK_TIMEOUT_BITS  = 20,
  parameter int ALIGN_TIMEOUT_BITS = 24,
  parameter int STABLE_CYCLES      = 1024,
  parameter int MAX_RETRIES        = 15
) (
  input  logic               i_clk,
  input  logic               i_reset_n,
  input  logic               i_restart,
  input  logic [LANES-1:0]   i_mgt_rxlock,
  input  logic [LANES-1:0]   i_xaui_sync,
  input  logic               i_xaui_align,
  input  logic               i_stats_clear,
  output logic               o_mgt_powerdown,
  output logic [LANES-1:0]   o_mgt_tx_reset,
  output logic [LANES-1:0]   o_mgt_rx_reset,
  output logic               o_xaui_reset,
  output logic               o_link_up,
  output logic [STATE_W-1:0] o_link_state,
  output logic [RETRY_W-1:0] o_retry_count,
  output logic [STAT_W-1:0]  o_flap_count,
  output logic [STAT_W-1:0]  o_timeout_count
);

  localparam int TW = max_int(LOCK_TIMEOUT_BITS, ALIGN_TIMEOUT_BITS);

  localparam logic [TW-1:0] L_PWRDN  = TW'(PWRDN_CYCLES - 1);
  localparam logic [TW-1:0] L_TXRST  = TW'(TX_RESET_CYCLES - 1);
  localparam logic [TW-1:0] L_RXRST  = TW'(RX_RESET_CYCLES - 1);
  localparam logic [TW-1:0] L_LOCK   = TW'((64'd1 << LOCK_TIMEOUT_BITS) - 64'd1);
  localparam logic [TW-1:0] L_ALIGN  = TW'((64'd1 << ALIGN_TIMEOUT_BITS) - 64'd1);
  localparam logic [TW-1:0] L_STABLE = TW'(STABLE_CYCLES - 1);

  state_t               r_state;
  state_t               w_next;
  state_t               w_target;
  logic                 w_lock;
  logic                 w_good;
  logic                 w_done;
  logic                 w_load;
  logic [TW-1:0]        w_load_val;
  logic                 w_retry;
  logic                 w_timeout;
  logic                 w_flap;
  logic                 w_retry_inc;
  logic                 w_tmo_inc;
  logic                 w_flap_inc;
  logic                 r_pwrdn;
  logic [LANES-1:0]     r_txrst;
  logic [LANES-1:0]     r_rxrst;
  logic                 r_xrst;
  logic                 r_up;
  logic [RETRY_W-1:0]   r_retry;

  assign w_lock = &i_mgt_rxlock;
  assign w_good = w_lock & (&i_xaui_sync) & i_xaui_align;

  always_comb begin
    w_next    = r_state;
    w_target  = ST_TXRST;
    w_retry   = 1'b0;
    w_timeout = 1'b0;
    w_flap    = 1'b0;
    case (r_state)
      ST_PWRDN:     if (w_done) w_next = ST_TXRST;
      ST_TXRST:     if (w_done) w_next = ST_RXRST;
      ST_RXRST:     if (w_done) w_next = ST_WAIT_LOCK;
      ST_WAIT_LOCK: begin
        if (w_lock) begin
          w_next = ST_WAIT_ALIGN;
        end else if (w_done) begin
          w_timeout = 1'b1;
          w_retry   = 1'b1;
          w_target  = ST_TXRST;
        end
      end
      ST_WAIT_ALIGN: begin
        if (!w_lock) begin
          w_retry  = 1'b1;
          w_target = ST_RXRST;
        end else if (w_good) begin
          w_next = ST_STABLE;
        end else if (w_done) begin
          w_timeout = 1'b1;
          w_retry   = 1'b1;
          w_target  = ST_RXRST;
        end
      end
      ST_STABLE: begin
        if (!w_good) begin
          w_retry  = 1'b1;
          w_target = ST_RXRST;
        end else if (w_done) begin
          w_next = ST_UP;
        end
      end
      ST_UP: begin
        if (!w_good) begin
          w_flap = 1'b1;
          w_next = ST_RXRST;
        end
      end
      default: w_next = r_state;
    endcase
    if (w_retry) w_next = (r_retry == RETRY_W'(MAX_RETRIES)) ? ST_FAIL : w_target;
    if (i_restart) w_next = ST_PWRDN;
  end

  assign w_retry_inc = w_retry & ~i_restart & (r_retry != RETRY_W'(MAX_RETRIES));
  assign w_tmo_inc   = w_timeout & ~i_restart;
  assign w_flap_inc  = w_flap & ~i_restart;

  // Every state entry reloads the timer, including a restart while already in PWRDN.
  always_comb begin
    w_load = i_restart | (w_next != r_state);
    case (w_next)
      ST_PWRDN:      w_load_val = L_PWRDN;
      ST_TXRST:      w_load_val = L_TXRST;
      ST_RXRST:      w_load_val = L_RXRST;
      ST_WAIT_LOCK:  w_load_val = L_LOCK;
      ST_WAIT_ALIGN: w_load_val = L_ALIGN;
      ST_STABLE:     w_load_val = L_STABLE;
      default:       w_load_val = '0;
    endcase
  end

  xaui_link_ctrl_timer #(
    .W       (TW),
    .RST_VAL (L_PWRDN)
  ) u_timer (
    .i_clk      (i_clk),
    .i_reset_n  (i_reset_n),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .o_done     (w_done)
  );

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= ST_PWRDN;
    end else begin
      r_state <= w_next;
    end
  end

  // Outputs decode w_next so they move on the same edge as the state.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_pwrdn <= 1'b1;
      r_txrst <= '1;
      r_rxrst <= '1;
      r_xrst  <= 1'b0;
      r_up    <= 1'b0;
      r_retry <= '0;
    end else begin
      r_pwrdn <= (w_next == ST_PWRDN);
      r_txrst <= {LANES{w_next inside {ST_PWRDN, ST_TXRST, ST_FAIL}}};
      r_rxrst <= {LANES{w_next inside {ST_PWRDN, ST_TXRST, ST_RXRST, ST_FAIL}}};
      r_xrst  <= (w_next == ST_WAIT_ALIGN) && (r_state != ST_WAIT_ALIGN);
      r_up    <= (w_next == ST_UP);
      if (i_restart || (w_next == ST_UP && r_state != ST_UP)) begin
        r_retry <= '0;
      end else if (w_retry_inc) begin
        r_retry <= r_retry + RETRY_W'(1);
      end
    end
  end

`ifdef XAUI_LINK_CTRL_STATS_EN
  logic [STAT_W-1:0] r_flap;
  logic [STAT_W-1:0] r_tmo;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_flap <= '0;
      r_tmo  <= '0;
    end else begin
      if (i_stats_clear) begin
        r_flap <= '0;
      end else if (w_flap_inc && r_flap != '1) begin
        r_flap <= r_flap + STAT_W'(1);
      end
      if (i_stats_clear) begin
        r_tmo <= '0;
      end else if (w_tmo_inc && r_tmo != '1) begin
        r_tmo <= r_tmo + STAT_W'(1);
      end
    end
  end

  assign o_flap_count    = r_flap;
  assign o_timeout_count = r_tmo;
`else
  logic w_unused_stats;
  assign w_unused_stats  = ^{i_stats_clear, w_flap_inc, w_tmo_inc};
  assign o_flap_count    = '0;
  assign o_timeout_count = '0;
`endif

  assign o_mgt_powerdown = r_pwrdn;
  assign o_mgt_tx_reset  = r_txrst;
  assign o_mgt_rx_reset  = r_rxrst;
  assign o_xaui_reset    = r_xrst;
  assign o_link_up       = r_up;
  assign o_link_state    = r_state;
  assign o_retry_count   = r_retry;

endmodule

// File: tb/tb_xaui_link_ctrl.sv
// tb/tb_xaui_link_ctrl.sv - scoreboard bench for xaui_link_ctrl, checked at every state entry
module tb_xaui_link_ctrl;

`ifdef XAUI_LINK_CTRL_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        restart = 1'b0;
  logic        stats_clear = 1'b0;
  logic [3:0]  rxlock = 4'hF;
  logic [3:0]  sync = 4'hF;
  logic        align = 1'b1;
  logic        pwrdn;
  logic [3:0]  tx_rst;
  logic [3:0]  rx_rst;
  logic        xrst;
  logic        link_up;
  logic [2:0]  link_state;
  logic [3:0]  retry_count;
  logic [15:0] flap_count;
  logic [15:0] timeout_count;

  always #5 clk = ~clk;

  xaui_link_ctrl #(
    .LOCK_TIMEOUT_BITS  (6),
    .ALIGN_TIMEOUT_BITS (12)
  ) u_dut (
    .i_clk           (clk),
    .i_reset_n       (reset_n),
    .i_restart       (restart),
    .i_mgt_rxlock    (rxlock),
    .i_xaui_sync     (sync),
    .i_xaui_align    (align),
    .i_stats_clear   (stats_clear),
    .o_mgt_powerdown (pwrdn),
    .o_mgt_tx_reset  (tx_rst),
    .o_mgt_rx_reset  (rx_rst),
    .o_xaui_reset    (xrst),
    .o_link_up       (link_up),
    .o_link_state    (link_state),
    .o_retry_count   (retry_count),
    .o_flap_count    (flap_count),
    .o_timeout_count (timeout_count)
  );

  typedef struct {
    int st;
    int dwell;
    int at;
    int retry;
    int flap;
    int tmo;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   ncyc = 0;
  int   e_retry = 0;
  int   e_flap = 0;
  int   e_tmo = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, ncyc, act, exp);
    end
  endtask

  task automatic push(input int st, input int dwell, input int at = -1);
    exp_t e;
    e.st    = st;
    e.dwell = dwell;
    e.at    = at;
    e.retry = e_retry;
    e.flap  = STATS ? e_flap : 0;
    e.tmo   = STATS ? e_tmo : 0;
    q.push_back(e);
  endtask

  task automatic drain(input int budget);
    int k;
    k = 0;
    while (q.size() != 0 && k < budget) begin
      @(posedge clk);
      k++;
    end
    if (q.size() != 0) begin
      chk("drain_timeout_pending", q.size(), 0);
      q.delete();
    end
    #1;
  endtask

  // Monitor: each state change pops one expected entry and checks state, prior dwell and outputs.
  initial begin
    int   prev;
    int   cnt;
    exp_t e;
    prev = 0;
    cnt  = 0;
    forever begin
      @(negedge clk);
      ncyc++;
      if (int'(link_state) != prev) begin
        if (q.size() == 0) begin
          chk("unexpected_transition", int'(link_state), prev);
        end else begin
          e = q.pop_front();
          chk("state", int'(link_state), e.st);
          if (e.dwell >= 0) chk("dwell_prev_state", cnt, e.dwell);
          if (e.at >= 0) chk("entry_cycle", ncyc, e.at);
          chk("retry_count", int'(retry_count), e.retry);
          chk("flap_count", int'(flap_count), e.flap);
          chk("timeout_count", int'(timeout_count), e.tmo);
          chk("mgt_powerdown", int'(pwrdn), (e.st == 0) ? 1 : 0);
          chk("mgt_tx_reset", int'(tx_rst), (e.st <= 1 || e.st == 7) ? 15 : 0);
          chk("mgt_rx_reset", int'(rx_rst), (e.st <= 2 || e.st == 7) ? 15 : 0);
          chk("xaui_reset", int'(xrst), (e.st == 4) ? 1 : 0);
          chk("link_up", int'(link_up), (e.st == 6) ? 1 : 0);
        end
        prev = int'(link_state);
        cnt  = 0;
      end
      if (reset_n) cnt++;
      else cnt = 0;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached with %0d entries pending", q.size());
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_state", int'(link_state), 0);
    chk("rst_powerdown", int'(pwrdn), 1);
    chk("rst_tx_reset", int'(tx_rst), 15);
    chk("rst_rx_reset", int'(rx_rst), 15);
    chk("rst_xaui_reset", int'(xrst), 0);
    chk("rst_link_up", int'(link_up), 0);
    chk("rst_retry", int'(retry_count), 0);
    chk("rst_flap", int'(flap_count), 0);
    chk("rst_timeout", int'(timeout_count), 0);

    // Clean bring-up with all status good
    push(1, 64); push(2, 16); push(3, 16); push(4, 1); push(5, 1); push(6, 1024);
    reset_n = 1'b1;
    drain(1500);

    // One-cycle sync loss on lane 2 while UP
    sync = 4'b1011;
    e_flap++;
    push(2, -1);
    @(posedge clk); #1 sync = 4'hF;
    push(3, 16); push(4, 1); push(5, 1); push(6, 1024);
    drain(1500);

    // stats_clear coincident with a flap
    sync = 4'b1011;
    stats_clear = 1'b1;
    e_flap = 0;
    e_tmo = 0;
    push(2, -1);
    @(posedge clk); #1;
    sync = 4'hF;
    stats_clear = 1'b0;
    push(3, 16); push(4, 1); push(5, 1); push(6, 1024);
    drain(1500);

    // Lane 3 never locks: 15 retries via TXRST, FAIL on the 16th timeout
    rxlock = 4'b0111;
    e_flap++;
    push(2, -1); push(3, 16);
    for (int k = 1; k <= 15; k++) begin
      e_tmo++;
      e_retry++;
      push(1, 64); push(2, 16); push(3, 16);
    end
    e_tmo++;
    push(7, 64);
    drain(3000);
    repeat (20) @(posedge clk);
    #1;

    // restart out of FAIL
    rxlock = 4'hF;
    n = ncyc;
    restart = 1'b1;
    e_retry = 0;
    push(0, -1, n + 2);
    @(posedge clk); #1 restart = 1'b0;
    push(1, 64); push(2, 16); push(3, 16); push(4, 1); push(5, 1); push(6, 1024);
    drain(1500);

    // Align drops every ~500 cycles in STABLE never reach UP
    align = 1'b0;
    e_flap++;
    push(2, -1);
    @(posedge clk); #1 align = 1'b1;
    push(3, 16); push(4, 1); push(5, 1);
    drain(200);
    for (int d = 1; d <= 3; d++) begin
      repeat (499) @(posedge clk);
      #1 align = 1'b0;
      e_retry++;
      push(2, -1);
      @(posedge clk); #1 align = 1'b1;
      push(3, 16); push(4, 1); push(5, 1);
      drain(200);
    end
    e_retry = 0;
    push(6, 1024);
    drain(1500);

    // Asynchronous reset while UP
    n = ncyc;
    reset_n = 1'b0;
    e_retry = 0;
    e_flap = 0;
    e_tmo = 0;
    push(0, -1, n + 1);
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    push(1, 64);
    drain(200);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/xaui_link_ctrl.md
# xaui_link_ctrl

Bring-up and recovery sequencer for the 4-lane XAUI PHY. Drives MGT powerdown, per-lane TX/RX resets and the XAUI core's status-reset request through a timed power-up order, then waits for lock, sync and alignment. On loss of link it retries with bounded timeouts and declares failure after a retry budget is exhausted. Sits beside `xaui_phy` in the 156.25 MHz user-clock domain, under software control.

## Interface
- `PWRDN_CYCLES`, 64: cycles `mgt_powerdown` is held after entry to PWRDN.
- `TX_RESET_CYCLES`, 16: cycles TX and RX resets are both held in TXRST.
- `RX_RESET_CYCLES`, 16: cycles RX reset is held in RXRST.
- `LOCK_TIMEOUT_BITS`, 20: WAIT_LOCK timeout = 2^N cycles.
- `ALIGN_TIMEOUT_BITS`, 24: WAIT_ALIGN timeout = 2^N cycles.
- `STABLE_CYCLES`, 1024: continuous good cycles required before UP.
- `MAX_RETRIES`, 15: retries before FAIL (1..15).
- `clk  in  1`: user clock; all logic rising-edge.
- `reset_n  in  1`: asynchronous, active-low reset.
- `restart  in  1`: 1-cycle pulse; restart the full sequence from PWRDN.
- `mgt_rxlock  in  4`: per-lane CDR lock.
- `xaui_sync  in  4`: per-lane sync status (core status bits 5:2).
- `xaui_align  in  1`: lane alignment (core status bit 6).
- `stats_clear  in  1`: clear statistics counters.
- `mgt_powerdown  out  1`: MGT power down.
- `mgt_tx_reset  out  4`: per-lane TX reset; all bits always equal.
- `mgt_rx_reset  out  4`: per-lane RX reset; all bits always equal.
- `xaui_reset  out  1`: reset request for the core's link and fault status bits.
- `link_up  out  1`: high only in UP.
- `link_state  out  3`: current state encoding.
- `retry_count  out  4`: retries since last UP or restart.
- `flap_count  out  16`: UP-to-down transitions, saturating.
- `timeout_count  out  16`: WAIT_LOCK and WAIT_ALIGN timeouts, saturating.

## Operation
- Define good = `&mgt_rxlock & &xaui_sync & xaui_align`.
- States and encodings:
  - PWRDN=0: powerdown=1, tx_reset=F, rx_reset=F. After PWRDN_CYCLES, go to TXRST.
  - TXRST=1: powerdown=0, tx_reset=F, rx_reset=F. After TX_RESET_CYCLES, go to RXRST.
  - RXRST=2: tx_reset=0, rx_reset=F. After RX_RESET_CYCLES, go to WAIT_LOCK.
  - WAIT_LOCK=3: wait for `&mgt_rxlock`, then go to WAIT_ALIGN. On timeout, take a retry with target TXRST.
  - WAIT_ALIGN=4: `xaui_reset`=1 for the first cycle only. When good, go to STABLE. If `&mgt_rxlock` is lost, take a retry with target RXRST. On timeout, take a retry with target RXRST.
  - STABLE=5: count STABLE_CYCLES consecutive good cycles, then go to UP. On any non-good cycle, take a retry with target RXRST.
  - UP=6: `link_up`=1. On the first non-good cycle, `flap_count`++ and go to RXRST. This does not count as a retry.
  - FAIL=7: powerdown=0, tx_reset=F, rx_reset=F. Held until `restart`.
- Retry: if `retry_count` == MAX_RETRIES, go to FAIL. Otherwise `retry_count`++ and go to the target state.
- `retry_count` clears on entry to UP and on `restart`.
- `restart` has priority over every transition. It forces PWRDN on the next edge and clears `retry_count`. It does not clear the statistics counters.
- Timeouts increment `timeout_count` in addition to the retry.
- All counters saturate and never wrap.
- `stats_clear` wins over a simultaneous increment; the counter becomes 0.

## Timing
- All outputs are registered and are decoded from the next-state value, so they change on the same edge as `link_state`.
- Reset values: state PWRDN, `mgt_powerdown`=1, `mgt_tx_reset`=F, `mgt_rx_reset`=F, `xaui_reset`=0, `link_up`=0, all counts 0.
- A state with an N-cycle hold lasts exactly N cycles: the phase timer loads N-1 on entry and exits at 0.
- The WAIT_LOCK timeout fires in the 2^LOCK_TIMEOUT_BITS-th cycle of the state. A qualifying input in that same cycle wins over the timeout.
- Inputs are already synchronous to `clk`; no synchronizers are inside this block.
- `reset_n` assertion mid-sequence returns the block to the reset values immediately (asynchronous).

## Configuration
- `XAUI_LINK_CTRL_STATS_EN` defined: `flap_count` and `timeout_count` are implemented as described.
- `XAUI_LINK_CTRL_STATS_EN` undefined: both ports are present and tied to 0, and `stats_clear` is ignored.
- `retry_count` is implemented in both builds.

## Structure
- `xaui_link_ctrl_pkg` holds:
  - the state enum and its 3-bit encodings;
  - the lane count constant (4);
  - the counter width constants.
- Sub-module `xaui_link_ctrl_timer`: a loadable down-counter with a `done` flag, shared by every hold and timeout phase. Its width is max(LOCK_TIMEOUT_BITS, ALIGN_TIMEOUT_BITS).

## Test plan
- Release `reset_n` with lock, sync and align all held good → PWRDN 64 cycles, TXRST 16, RXRST 16, one cycle in WAIT_LOCK, WAIT_ALIGN with a 1-cycle `xaui_reset`, STABLE 1024 cycles, then `link_up`=1.
- With the link UP, drop `xaui_sync[2]` for 1 cycle → next state RXRST, `flap_count`=1, `retry_count`=0, then re-acquire to UP.
- Hold `mgt_rxlock`=4'b0111, with LOCK_TIMEOUT_BITS reduced to 6 → retry via TXRST 15 times, then FAIL on the 16th timeout, `timeout_count`=16, resets held.
- From FAIL, pulse `restart` → PWRDN next cycle, `retry_count`=0, `timeout_count` unchanged.
- Toggle `xaui_align` low once every 500 cycles in STABLE → never reaches UP, `retry_count` increments once per drop.
- Assert `stats_clear` in the same cycle as a flap → `flap_count`=0; without the macro, both stats ports read 0 throughout.
